// File: rtl/apb_master_if.sv
// Command, response and APB bus signals of the APB requester, bundled with
// a master view for the requester and a slave view for whatever sits around it.
interface apb_master_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic              p_sel;
  logic              p_enable;
  logic              p_write;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_w_data;
  logic              p_ready;
  logic [DATA_W-1:0] p_r_data;
  logic              p_slv_err;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output p_sel, p_enable, p_write, p_addr, p_w_data,
    input  p_ready, p_r_data, p_slv_err
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  p_sel, p_enable, p_write, p_addr, p_w_data,
    output p_ready, p_r_data, p_slv_err
  );

endinterface

// File: rtl/apb_master.sv
// APB requester: takes one command at a time, runs SETUP/ACCESS with wait
// states and an optional ACCESS timeout, and returns a one-cycle response.
module apb_master #(
  parameter int ADDR_W         = 2,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic         p_clk,
  input  logic         p_rst,
  apb_master_if.master bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  assign bus.cmd_ready = (state == IDLE) && !p_rst;

  // The abort check uses the count before this edge's increment, so the
  // transfer gives up on its TIMEOUT_CYCLES-th ACCESS cycle without p_ready.
  always_ff @(posedge p_clk) begin
    if (p_rst) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      bus.p_sel       <= 1'b0;
      bus.p_enable    <= 1'b0;
      bus.p_write     <= 1'b0;
      bus.p_addr      <= '0;
      bus.p_w_data    <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_err     <= 1'b0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            bus.p_write  <= bus.cmd_write;
            bus.p_addr   <= ADDR_W'(bus.cmd_addr);
            bus.p_w_data <= DATA_W'(bus.cmd_wdata);
            bus.p_sel    <= 1'b1;
            bus.p_enable <= 1'b0;
            state        <= SETUP;
          end
        end
        SETUP: begin
          bus.p_enable <= 1'b1;
          wait_cnt     <= '0;
          state        <= ACCESS;
        end
        ACCESS: begin
          if (bus.p_ready) begin
            bus.p_sel       <= 1'b0;
            bus.p_enable    <= 1'b0;
            bus.rsp_valid   <= 1'b1;
            bus.rsp_rdata   <= bus.p_write ? DATA_W'(0) : bus.p_r_data;
            bus.rsp_err     <= bus.p_slv_err;
            bus.rsp_timeout <= 1'b0;
            state           <= IDLE;
          end else if (TIMEOUT_CYCLES != 0 &&
                       wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            bus.p_sel       <= 1'b0;
            bus.p_enable    <= 1'b0;
            bus.rsp_valid   <= 1'b1;
            bus.rsp_rdata   <= '0;
            bus.rsp_err     <= 1'b1;
            bus.rsp_timeout <= 1'b1;
            state           <= IDLE;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed transfers against a small
// APB slave, with an edge-count transaction model compared every cycle.
module tb_apb_master;

  localparam int TO = 16;

  logic p_clk;
  logic p_rst;

  apb_master_if #(.ADDR_W(2), .DATA_W(32)) bus ();

  apb_master #(.ADDR_W(2), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .p_clk (p_clk),
    .p_rst (p_rst),
    .bus   (bus)
  );

  initial p_clk = 1'b0;
  always #5 p_clk = ~p_clk;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Slave: knobs set by the stimulus decide wait states, error and stuck-low ready.
  logic [31:0] slv_mem [4];
  int          slv_waits = 0;
  logic        slv_err   = 1'b0;
  logic        slv_stuck = 1'b0;
  int          acc_cnt   = 0;

  always @(negedge p_clk) begin
    logic rdy;
    if (bus.p_sel && bus.p_enable) begin
      rdy = !slv_stuck && (acc_cnt >= slv_waits);
      acc_cnt++;
    end else begin
      rdy = 1'b0;
      acc_cnt = 0;
    end
    bus.p_ready   = rdy;
    bus.p_r_data  = slv_mem[bus.p_addr];
    bus.p_slv_err = rdy && slv_err;
    if (rdy && bus.p_write && !slv_err) slv_mem[bus.p_addr] = bus.p_w_data;
  end

  // Transaction model: edges are counted from acceptance; SETUP is one edge,
  // ACCESS edges follow until p_ready or the TO-th ACCESS edge.
  int          cyc = 0;
  int          acc = 0;
  bit          busy = 1'b0;
  bit          seen_rst = 1'b0;
  logic        m_sel = 0, m_en = 0, m_write = 0, m_rsp = 0, m_err = 0, m_to = 0;
  logic [1:0]  m_addr = 0;
  logic [31:0] m_wdata = 0, m_rdata = 0;

  always @(posedge p_clk) begin
    cyc++;
    m_rsp = 1'b0;
    if (p_rst) begin
      seen_rst = 1'b1;
      busy = 1'b0;
      {m_sel, m_en, m_write, m_err, m_to} = '0;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
    end else if (!busy) begin
      if (bus.cmd_valid) begin
        busy = 1'b1; acc = cyc;
        m_write = bus.cmd_write; m_addr = bus.cmd_addr; m_wdata = bus.cmd_wdata;
        m_sel = 1'b1; m_en = 1'b0;
      end
    end else if (cyc == acc + 1) begin
      m_en = 1'b1;
    end else if (bus.p_ready) begin
      busy = 1'b0; m_sel = 1'b0; m_en = 1'b0; m_rsp = 1'b1;
      m_rdata = m_write ? 32'h0 : bus.p_r_data;
      m_err = bus.p_slv_err; m_to = 1'b0;
    end else if (TO != 0 && cyc - acc - 1 == TO) begin
      busy = 1'b0; m_sel = 1'b0; m_en = 1'b0; m_rsp = 1'b1;
      m_rdata = 32'h0; m_err = 1'b1; m_to = 1'b1;
    end
  end

  always @(posedge p_clk) begin
    #1;
    if (seen_rst) begin
      checkOutput("cmd_ready",   32'(bus.cmd_ready),   32'(!busy && !p_rst));
      checkOutput("p_sel",       32'(bus.p_sel),       32'(m_sel));
      checkOutput("p_enable",    32'(bus.p_enable),    32'(m_en));
      checkOutput("p_write",     32'(bus.p_write),     32'(m_write));
      checkOutput("p_addr",      32'(bus.p_addr),      32'(m_addr));
      checkOutput("p_w_data",    bus.p_w_data,         m_wdata);
      checkOutput("rsp_valid",   32'(bus.rsp_valid),   32'(m_rsp));
      checkOutput("rsp_rdata",   bus.rsp_rdata,        m_rdata);
      checkOutput("rsp_err",     32'(bus.rsp_err),     32'(m_err));
      checkOutput("rsp_timeout", 32'(bus.rsp_timeout), 32'(m_to));
      checkOutput("en_without_sel", 32'(bus.p_enable && !bus.p_sel), 32'h0);
    end
  end

  // One command; lat is the number of edges from acceptance to the response edge.
  task automatic applyStimulus(input logic wr, input logic [1:0] addr,
                               input logic [31:0] wdata, input int waits,
                               input logic err, input logic stuck, output int lat);
    int t;
    @(negedge p_clk);
    slv_waits = waits; slv_err = err; slv_stuck = stuck;
    bus.cmd_write = wr; bus.cmd_addr = addr; bus.cmd_wdata = wdata;
    bus.cmd_valid = 1'b1;
    t = 0;
    while (!bus.cmd_ready && t < 50) begin
      @(negedge p_clk);
      t++;
    end
    checkOutput("accept_ready", 32'(bus.cmd_ready), 32'h1);
    @(posedge p_clk); #1;
    checkOutput("setup_sel", 32'(bus.p_sel), 32'h1);
    checkOutput("setup_en",  32'(bus.p_enable), 32'h0);
    @(negedge p_clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_wdata = ~wdata;
    lat = 0;
    while (!bus.rsp_valid && lat < 40) begin
      @(posedge p_clk); #1;
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    int rv_seen;
    int n;
    int times [8];

    slv_mem[0] = 32'h0; slv_mem[1] = 32'h1111_2222;
    slv_mem[2] = 32'h3333_4444; slv_mem[3] = 32'h5555_6666;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.p_ready = 1'b0; bus.p_r_data = '0; bus.p_slv_err = 1'b0;
    p_rst = 1'b1;

    repeat (2) @(posedge p_clk);
    #1;
    checkOutput("rst_p_sel",     32'(bus.p_sel), 32'h0);
    checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 32'h0);
    @(negedge p_clk);
    p_rst = 1'b0;
    #1;
    checkOutput("idle_cmd_ready", 32'(bus.cmd_ready), 32'h1);

    $display("[TB] write zero wait");
    applyStimulus(1'b1, 2'd0, 32'hA5A5_0001, 0, 1'b0, 1'b0, lat);
    checkOutput("wr_latency", 32'(lat), 32'd2);
    checkOutput("wr_rdata",   bus.rsp_rdata, 32'h0);
    checkOutput("wr_err",     32'(bus.rsp_err), 32'h0);

    $display("[TB] read after write");
    applyStimulus(1'b0, 2'd0, 32'h0, 0, 1'b0, 1'b0, lat);
    checkOutput("rd_rdata",   bus.rsp_rdata, 32'hA5A5_0001);
    checkOutput("rd_err",     32'(bus.rsp_err), 32'h0);
    checkOutput("rd_timeout", 32'(bus.rsp_timeout), 32'h0);

    $display("[TB] slave error");
    applyStimulus(1'b1, 2'd3, 32'hDEAD_BEEF, 0, 1'b1, 1'b0, lat);
    checkOutput("err_err",     32'(bus.rsp_err), 32'h1);
    checkOutput("err_timeout", 32'(bus.rsp_timeout), 32'h0);
    checkOutput("err_idle",    32'(bus.cmd_ready), 32'h1);

    $display("[TB] two wait states");
    applyStimulus(1'b0, 2'd1, 32'h0BAD_F00D, 2, 1'b0, 1'b0, lat);
    checkOutput("wait_latency", 32'(lat), 32'd4);
    checkOutput("wait_rdata",   bus.rsp_rdata, 32'h1111_2222);

    $display("[TB] timeout");
    applyStimulus(1'b1, 2'd2, 32'hCAFE_0002, 0, 1'b0, 1'b1, lat);
    checkOutput("to_latency", 32'(lat), 32'd17);
    checkOutput("to_p_sel",   32'(bus.p_sel), 32'h0);
    checkOutput("to_err",     32'(bus.rsp_err), 32'h1);
    checkOutput("to_timeout", 32'(bus.rsp_timeout), 32'h1);
    checkOutput("to_rdata",   bus.rsp_rdata, 32'h0);
    applyStimulus(1'b1, 2'd2, 32'hCAFE_0003, 0, 1'b0, 1'b0, lat);
    checkOutput("post_to_latency", 32'(lat), 32'd2);
    checkOutput("post_to_err",     32'(bus.rsp_err), 32'h0);
    checkOutput("post_to_timeout", 32'(bus.rsp_timeout), 32'h0);

    $display("[TB] reset during ACCESS");
    @(negedge p_clk);
    slv_stuck = 1'b1;
    bus.cmd_write = 1'b0; bus.cmd_addr = 2'd2; bus.cmd_valid = 1'b1;
    @(posedge p_clk);
    @(negedge p_clk);
    bus.cmd_valid = 1'b0;
    repeat (3) @(negedge p_clk);
    p_rst = 1'b1;
    @(posedge p_clk); #1;
    checkOutput("mid_rst_p_sel",     32'(bus.p_sel), 32'h0);
    checkOutput("mid_rst_p_enable",  32'(bus.p_enable), 32'h0);
    checkOutput("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    checkOutput("mid_rst_p_addr",    32'(bus.p_addr), 32'h0);
    @(negedge p_clk);
    p_rst = 1'b0;
    slv_stuck = 1'b0;
    rv_seen = 0;
    repeat (4) begin
      @(posedge p_clk); #1;
      if (bus.rsp_valid) rv_seen++;
    end
    checkOutput("mid_rst_no_rsp", 32'(rv_seen), 32'h0);

    $display("[TB] back-to-back with cmd_valid held");
    @(negedge p_clk);
    slv_waits = 0; slv_err = 1'b0;
    bus.cmd_write = 1'b0; bus.cmd_addr = 2'd1; bus.cmd_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge p_clk); #1;
      if (bus.rsp_valid && n < 8) begin
        times[n] = cyc;
        n++;
      end
    end
    @(negedge p_clk);
    bus.cmd_valid = 1'b0;
    checkOutput("b2b_count", 32'(n), 32'd4);
    for (int i = 1; i < 4; i++) begin
      if (i < n) checkOutput("b2b_spacing", 32'(times[i] - times[i-1]), 32'd3);
    end

    repeat (5) @(posedge p_clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
